// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and
// the width helper used for the grant index and internal counters.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_e;

  // Bits needed to index n items; never less than one bit.
  function automatic int unsigned grant_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner search: first set request starting at ptr_i, wrapping.
module rr_pick
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned GW      = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GW-1:0]      ptr_i,
  output logic [GW-1:0]      idx_o,
  output logic               found_o
);

  logic [GW-1:0] cand;

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = GW'((32'(ptr_i) + k) % NUM_REQ);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers,
// with frame-done/timeout wait and optional inter-frame gap.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int unsigned NUM_REQ        = 4,
  parameter  int unsigned GAP_CYCLES     = 0,
  parameter  int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned GRANT_W        = grant_w(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  input  logic                 tx_done,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned      TO_W     = grant_w(TIMEOUT_CYCLES);
  localparam int unsigned      GAP_W    = grant_w(GAP_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  arb_state_e         state_q, state_d;
  logic [GRANT_W-1:0] ptr_q, ptr_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_valid_q, tx_valid_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;

  logic [GRANT_W-1:0] pick_idx;
  logic               found;
  logic               grant_fire, timed_out, frame_end;
  logic [7:0]         lane [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane[i] = req_data[8*i +: 8];
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (found)
  );

  // req_ready is combinational, so it is also held off while reset is asserted.
  assign grant_fire = rst_n && (state_q == IDLE) && found;
  assign timed_out  = (state_q == WAIT_DONE) && !tx_done && (to_cnt_q == TO_LAST);
  assign frame_end  = (state_q == WAIT_DONE) && (tx_done || timed_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (found) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_DONE;
      WAIT_DONE: if (frame_end) state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:       if (gap_cnt_q == '0) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;

    if (grant_fire) begin
      req_ready = NUM_REQ'(1) << pick_idx;
      tx_data_d = lane[pick_idx];
      grant_d   = pick_idx;
      ptr_d     = GRANT_W'((32'(pick_idx) + 1) % NUM_REQ);
    end

    if (state_q == LAUNCH) to_cnt_d = '0;
    if ((state_q == WAIT_DONE) && !frame_end) to_cnt_d = to_cnt_q + 1'b1;

    if (frame_end && (GAP_CYCLES > 0)) gap_cnt_d = GAP_LOAD;
    if ((state_q == GAP) && (gap_cnt_q != '0)) gap_cnt_d = gap_cnt_q - 1'b1;

    tx_valid_d = (state_d == LAUNCH);
    busy_d     = (state_d != IDLE);
    timeout_d  = timed_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      grant_q    <= '0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: instance A (no gap) and instance B (gap 3, timeout 8).
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  a_req_valid, b_req_valid;
  logic [31:0] a_req_data, b_req_data;
  logic [3:0]  a_req_ready, b_req_ready;
  logic        a_tx_valid, b_tx_valid;
  logic [7:0]  a_tx_data, b_tx_data;
  logic        a_tx_done, b_tx_done;
  logic [1:0]  a_grant_id, b_grant_id;
  logic        a_busy, b_busy;
  logic        a_timeout_err, b_timeout_err;

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_data(a_req_data),
    .req_ready(a_req_ready), .tx_valid(a_tx_valid), .tx_data(a_tx_data),
    .tx_done(a_tx_done), .grant_id(a_grant_id), .busy(a_busy),
    .timeout_err(a_timeout_err)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .GAP_CYCLES(3), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_data(b_req_data),
    .req_ready(b_req_ready), .tx_valid(b_tx_valid), .tx_data(b_tx_data),
    .tx_done(b_tx_done), .grant_id(b_grant_id), .busy(b_busy),
    .timeout_err(b_timeout_err)
  );

  typedef struct {
    logic [3:0]  vld;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic [1:0]  exp_gid;
    logic [7:0]  exp_data;
  } vec_t;

  typedef struct {
    logic [1:0] gid;
    logic [7:0] data;
  } exp_t;

  vec_t tbl [8];
  exp_t sb_q [$];
  int   rdy_cnt [4];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Scoreboard side: every launch on instance A must match the oldest grant expectation.
  always @(negedge clk) begin
    #3;
    if (a_tx_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected got=launch gid=%0d exp=none", a_grant_id);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_data", 32'(a_tx_data), 32'(e.data));
        chk("sb_gid", 32'(a_grant_id), 32'(e.gid));
      end
    end
    for (int i = 0; i < 4; i++) if (a_req_ready[i] === 1'b1) rdy_cnt[i]++;
  end

  task automatic wait_tx_a(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (a_tx_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_frame(input vec_t v);
    @(negedge clk);
    a_req_valid = v.vld;
    a_req_data  = v.data;
    #1;
    chk("tbl_ready", 32'(a_req_ready), 32'(v.exp_ready));
    sb_q.push_back('{gid: v.exp_gid, data: v.exp_data});
    @(negedge clk);
    a_req_valid = '0;
    #1;
    chk("tbl_txvalid", 32'(a_tx_valid), 32'd1);
    chk("tbl_gid", 32'(a_grant_id), 32'(v.exp_gid));
    chk("tbl_data", 32'(a_tx_data), 32'(v.exp_data));
    @(negedge clk); #1;
    chk("tbl_txvalid_once", 32'(a_tx_valid), 32'd0);
    chk("tbl_busy", 32'(a_busy), 32'd1);
    @(negedge clk);
    a_tx_done = 1'b1;
    @(negedge clk);
    a_tx_done = 1'b0;
    #1;
    chk("tbl_idle_after_done", 32'(a_busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    tbl[0] = '{4'b0100, 32'h00A5_0000, 4'b0100, 2'd2, 8'hA5};
    tbl[1] = '{4'b1001, 32'h2300_0020, 4'b1000, 2'd3, 8'h23};
    tbl[2] = '{4'b1001, 32'h3300_0030, 4'b0001, 2'd0, 8'h30};
    tbl[3] = '{4'b0001, 32'h0000_0040, 4'b0001, 2'd0, 8'h40};
    tbl[4] = '{4'b0110, 32'h0052_5100, 4'b0010, 2'd1, 8'h51};
    tbl[5] = '{4'b0011, 32'h0000_6160, 4'b0001, 2'd0, 8'h60};
    tbl[6] = '{4'b1111, 32'h7372_7170, 4'b0010, 2'd1, 8'h71};
    tbl[7] = '{4'b1000, 32'h8300_0000, 4'b1000, 2'd3, 8'h83};

    a_req_valid = '0; a_req_data = '0; a_tx_done = 1'b0;
    b_req_valid = '0; b_req_data = '0; b_tx_done = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    a_req_valid = 4'hF;
    #2;
    chk("rst_ready", 32'(a_req_ready), 32'd0);
    chk("rst_txvalid", 32'(a_tx_valid), 32'd0);
    chk("rst_txdata", 32'(a_tx_data), 32'd0);
    chk("rst_gid", 32'(a_grant_id), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_timeout", 32'(a_timeout_err), 32'd0);
    a_req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table: grants, pointer advance and wrap (ptr=3 with 1001 gives 3 then 0).
    for (int e = 0; e < 8; e++) do_frame(tbl[e]);

    // tx_done while idle must not start anything.
    @(negedge clk); a_tx_done = 1'b1;
    @(negedge clk); a_tx_done = 1'b0; #1;
    chk("stray_done_busy", 32'(a_busy), 32'd0);
    chk("stray_done_txvalid", 32'(a_tx_valid), 32'd0);

    // All four requesters held valid; tx_done 20 cycles after each launch.
    for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;
    sb_q.push_back('{gid: 2'd0, data: 8'h10});
    sb_q.push_back('{gid: 2'd1, data: 8'h11});
    sb_q.push_back('{gid: 2'd2, data: 8'h12});
    sb_q.push_back('{gid: 2'd3, data: 8'h13});
    sb_q.push_back('{gid: 2'd0, data: 8'h10});
    @(negedge clk);
    a_req_valid = 4'hF;
    a_req_data  = 32'h1312_1110;
    for (int f = 0; f < 5; f++) begin
      wait_tx_a(ok);
      chk("rr_launch_seen", 32'(ok), 32'd1);
      if (f == 4) a_req_valid = '0;
      repeat (20) @(negedge clk);
      a_tx_done = 1'b1;
      @(negedge clk);
      a_tx_done = 1'b0;
    end
    @(negedge clk); #1;
    chk("rr_ready_cnt0", 32'(rdy_cnt[0]), 32'd2);
    chk("rr_ready_cnt1", 32'(rdy_cnt[1]), 32'd1);
    chk("rr_ready_cnt2", 32'(rdy_cnt[2]), 32'd1);
    chk("rr_ready_cnt3", 32'(rdy_cnt[3]), 32'd1);
    chk("rr_idle", 32'(a_busy), 32'd0);

    // Reset while in WAIT_DONE; pointer must restart at 0 afterwards.
    @(negedge clk);
    a_req_valid = 4'b0100;
    a_req_data  = 32'h00C7_0000;
    #1;
    chk("rstmid_ready", 32'(a_req_ready), 32'b0100);
    sb_q.push_back('{gid: 2'd2, data: 8'hC7});
    @(negedge clk); a_req_valid = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_txvalid", 32'(a_tx_valid), 32'd0);
    chk("rstmid_txdata", 32'(a_tx_data), 32'd0);
    chk("rstmid_gid", 32'(a_grant_id), 32'd0);
    chk("rstmid_busy", 32'(a_busy), 32'd0);
    chk("rstmid_timeout", 32'(a_timeout_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("post_rst_txvalid", 32'(a_tx_valid), 32'd0);
      chk("post_rst_ready", 32'(a_req_ready), 32'd0);
    end
    do_frame('{4'b1010, 32'h3D00_2D00, 4'b0010, 2'd1, 8'h2D});

    // Instance B: timeout 8 cycles after entering WAIT_DONE, then a 3-cycle gap.
    @(negedge clk);
    b_req_valid = 4'b0001;
    b_req_data  = 32'h0000_005A;
    #1;
    chk("to_ready", 32'(b_req_ready), 32'b0001);
    @(negedge clk); b_req_valid = '0; #1;
    chk("to_txvalid", 32'(b_tx_valid), 32'd1);
    chk("to_txdata", 32'(b_tx_data), 32'h5A);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); #1;
      chk($sformatf("to_err_k%0d", k), 32'(b_timeout_err), 32'(k == 9));
      chk($sformatf("to_busy_k%0d", k), 32'(b_busy), 32'(k < 12));
    end

    // Back-to-back with gap: ptr=1 so 0011 grants 1 first, then 0 after the gap.
    @(negedge clk);
    b_req_valid = 4'b0011;
    b_req_data  = 32'h0000_6766;
    #1;
    chk("gap_ready1", 32'(b_req_ready), 32'b0010);
    @(negedge clk); #1;
    chk("gap_launch1", 32'(b_tx_valid), 32'd1);
    chk("gap_data1", 32'(b_tx_data), 32'h67);
    chk("gap_gid1", 32'(b_grant_id), 32'd1);
    @(negedge clk); b_tx_done = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk); b_tx_done = 1'b0; #1;
      chk($sformatf("gap_ready_j%0d", j), 32'(b_req_ready), (j == 4) ? 32'b0001 : 32'd0);
      chk($sformatf("gap_busy_j%0d", j), 32'(b_busy), 32'(j < 4));
    end
    @(negedge clk); b_req_valid = '0; #1;
    chk("gap_launch2", 32'(b_tx_valid), 32'd1);
    chk("gap_data2", 32'(b_tx_data), 32'h66);
    chk("gap_gid2", 32'(b_grant_id), 32'd0);

    // tx_done coinciding with the last timeout count: done wins.
    for (int m = 1; m <= 8; m++) begin
      @(negedge clk);
      if (m == 8) b_tx_done = 1'b1;
    end
    @(negedge clk); b_tx_done = 1'b0; #1;
    chk("tie_timeout_err", 32'(b_timeout_err), 32'd0);
    chk("tie_busy_gap", 32'(b_busy), 32'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("tie_idle", 32'(b_busy), 32'd0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single UART transmitter among NUM_REQ byte-producing requesters using round-robin arbitration. Each granted byte is captured, launched into the transmitter with a one-cycle valid strobe, and the arbiter waits for frame completion (or timeout) plus an optional inter-frame gap before granting again. The block sits between the client logic (command/status producers) and the uart_tx datapath.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- GAP_CYCLES, 0: idle clock cycles inserted after each frame completes (0 = none).
- TIMEOUT_CYCLES, 65535: maximum cycles spent waiting for tx_done before aborting the frame (must be ≥ 2).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte available; held high with req_data stable until req_ready.
- req_data  in  8*NUM_REQ  requester i's byte at bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse; the byte is taken that cycle.
- tx_valid  out  1  one-cycle launch strobe to the transmitter.
- tx_data  out  8  registered byte to transmit; stable from launch until the next grant.
- tx_done  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
- grant_id  out  clog2(NUM_REQ)  index of the requester currently owning the transmitter.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse when a frame is aborted on timeout.

## Operation
- States: IDLE, LAUNCH, WAIT_DONE, GAP.
- Round-robin pointer ptr, reset to 0. Search order: ptr, ptr+1, …, wrapping modulo NUM_REQ. The first index with req_valid set wins.
- IDLE, any req_valid set:
  - grant winner g;
  - pulse req_ready[g];
  - tx_data <= req_data[g], grant_id <= g;
  - ptr <= (g+1) mod NUM_REQ;
  - go to LAUNCH.
- IDLE, no req_valid: stay; all outputs hold.
- LAUNCH: tx_valid=1 for exactly this cycle; clear the timeout counter; go to WAIT_DONE.
- WAIT_DONE, tx_done=1: go to GAP if GAP_CYCLES>0 (load gap counter to GAP_CYCLES-1), otherwise go to IDLE.
- WAIT_DONE, no tx_done: increment the timeout counter. When the counter reaches TIMEOUT_CYCLES-1, pulse timeout_err and leave exactly as a tx_done would.
- If tx_done and timeout coincide in the same cycle, tx_done wins and timeout_err stays 0.
- GAP: decrement the gap counter; go to IDLE in the cycle the counter is 0.
- tx_done outside WAIT_DONE is ignored.
- A requester that drops req_valid before being granted is simply skipped; no state is kept for it.
- Pointer update occurs only on a grant, never on a timeout.

## Timing
- Reset values: req_ready=0, tx_valid=0, tx_data=0, grant_id=0, busy=0, timeout_err=0, state=IDLE, ptr=0, all counters 0.
- Asynchronous reset mid-frame aborts immediately; no req_ready or tx_valid is emitted afterwards until a new grant.
- Grant latency: req_valid sampled high in IDLE at cycle T gives req_ready at T and tx_valid at T+1.
- Minimum re-grant spacing after tx_done at cycle D (GAP_CYCLES=0): next req_ready at D+1.
- With GAP_CYCLES=G>0: next req_ready no earlier than D+1+G.
- All outputs are registered except req_ready, which is a decode of state==IDLE and the winner. This is acceptable because requesters sample it on the same edge.
- Counter widths: timeout counter clog2(TIMEOUT_CYCLES); gap counter clog2(GAP_CYCLES+1), minimum 1 bit.

## Structure
- Shared package uart_pkg:
  - arbiter state enumeration/localparams (IDLE=2'd0, LAUNCH=2'd1, WAIT_DONE=2'd2, GAP=2'd3);
  - GRANT_W derivation helper.
- Sub-module rr_pick: given req vector and ptr, returns the winner index and a found flag. It is purely combinational and is instantiated once.
- The uart_tx instance is outside this block; the top level wires tx_valid/tx_data/tx_done.

## Test plan
- Single request, NUM_REQ=4, GAP=0: req_valid=4'b0100, data 0xA5 -> req_ready=4'b0100 at T, tx_valid at T+1 with tx_data=0xA5, grant_id=2; tx_done -> IDLE next cycle, ptr=3.
- All four requesters hold valid with data 0x10,0x11,0x12,0x13 -> frames launched in order 0,1,2,3,0 with tx_done returned 20 cycles after each launch; each req_ready exactly once per frame.
- Starvation/wrap: ptr=3, req_valid=4'b1001 -> grant 3, then 0; never 0 twice in a row while 3 is still valid.
- Timeout with TIMEOUT_CYCLES=8 and tx_done never returned -> timeout_err pulses 8 cycles after the WAIT_DONE entry; state returns to IDLE; next request is granted normally.
- GAP_CYCLES=3: back-to-back requests -> exactly 3 cycles between the tx_done cycle+1 and the next req_ready; busy stays high through the gap.
- Reset asserted in WAIT_DONE -> all outputs 0 asynchronously. After release with req_valid=4'b0010 -> grant 1 with ptr starting from 0.
